// File: rtl/alarm_time_source_pkg.sv
// Shared widths, BCD digit positions, time limits and the legal-time check
// used by the alarm time source and its time counter.
package alarm_time_source_pkg;
  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 16;

  localparam int HT_LSB = 12;
  localparam int HU_LSB = 8;
  localparam int MT_LSB = 4;
  localparam int MU_LSB = 0;

  localparam logic [DIGIT_W-1:0] MAX_HT        = 4'd2;
  localparam logic [DIGIT_W-1:0] MAX_HU_AT_HT2 = 4'd3;
  localparam logic [DIGIT_W-1:0] MAX_MT        = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT     = 4'd9;

  typedef struct packed {
    logic alarm;
    logic new_time;
  } load_req_t;

  function automatic logic is_legal_time(input logic [TIME_W-1:0] t);
    logic [DIGIT_W-1:0] ht, hu, mt, mu;
    ht = t[HT_LSB +: DIGIT_W];
    hu = t[HU_LSB +: DIGIT_W];
    mt = t[MT_LSB +: DIGIT_W];
    mu = t[MU_LSB +: DIGIT_W];
    return (ht <= MAX_HT) && (hu <= MAX_DIGIT) &&
           ((ht != MAX_HT) || (hu <= MAX_HU_AT_HT2)) &&
           (mt <= MAX_MT) && (mu <= MAX_DIGIT);
  endfunction
endpackage

// File: rtl/alarm_time_source_bcd_time_counter.sv
// BCD HH:MM time-of-day counter: one-minute tick with minute/hour carry and
// 23:59 wrap; a load overrides a coincident tick.
module bcd_time_counter
  import alarm_time_source_pkg::*;
#(
  parameter logic [15:0] RST_TIME = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] time_bcd
);
  logic [DIGIT_W-1:0] ht, hu, mt, mu;
  logic [TIME_W-1:0]  nxt_time;

  assign ht = time_bcd[HT_LSB +: DIGIT_W];
  assign hu = time_bcd[HU_LSB +: DIGIT_W];
  assign mt = time_bcd[MT_LSB +: DIGIT_W];
  assign mu = time_bcd[MU_LSB +: DIGIT_W];

  always_comb begin
    nxt_time = time_bcd;
    if (mu != MAX_DIGIT) begin
      nxt_time[MU_LSB +: DIGIT_W] = mu + 4'd1;
    end else begin
      nxt_time[MU_LSB +: DIGIT_W] = '0;
      if (mt != MAX_MT) begin
        nxt_time[MT_LSB +: DIGIT_W] = mt + 4'd1;
      end else begin
        nxt_time[MT_LSB +: DIGIT_W] = '0;
        // Hour carry: 23 wraps to 00, x9 rolls into the tens digit.
        if (ht == MAX_HT && hu == MAX_HU_AT_HT2) begin
          nxt_time[HT_LSB +: DIGIT_W] = '0;
          nxt_time[HU_LSB +: DIGIT_W] = '0;
        end else if (hu == MAX_DIGIT) begin
          nxt_time[HU_LSB +: DIGIT_W] = '0;
          nxt_time[HT_LSB +: DIGIT_W] = ht + 4'd1;
        end else begin
          nxt_time[HU_LSB +: DIGIT_W] = hu + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     time_bcd <= RST_TIME;
    else if (load)  time_bcd <= load_value;
    else if (tick)  time_bcd <= nxt_time;
  end
endmodule

// File: rtl/alarm_time_source.sv
// Keypad entry buffer, alarm register and time-of-day counter feeding the
// alarm comparator/display mux with BCD HHMM buses.
module alarm_time_source
  import alarm_time_source_pkg::*;
#(
  parameter logic [15:0] RST_TIME  = 16'h0000,
  parameter logic [15:0] RST_ALARM = 16'h0600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        one_minute,
  input  logic [3:0]  key,
  input  logic        key_valid,
  input  logic        load_alarm,
  input  logic        load_new_time,
  output logic [15:0] key_buffer,
  output logic [15:0] alarm_time,
  output logic [15:0] current_time,
  output logic        load_error
);
  load_req_t ld;
  logic      legal, any_load;

  assign ld       = '{alarm: load_alarm, new_time: load_new_time};
  assign any_load = ld.alarm | ld.new_time;
  assign legal    = is_legal_time(key_buffer);

  // A load always clears the buffer and swallows any coincident key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_buffer <= '0;
      alarm_time <= RST_ALARM;
      load_error <= 1'b0;
    end else begin
      load_error <= any_load & ~legal;
      if (ld.alarm && legal) alarm_time <= key_buffer;
      if (any_load)
        key_buffer <= '0;
      else if (key_valid && key <= MAX_DIGIT)
        key_buffer <= {key_buffer[TIME_W-DIGIT_W-1:0], key};
    end
  end

  bcd_time_counter #(.RST_TIME(RST_TIME)) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (one_minute),
    .load       (ld.new_time & legal),
    .load_value (key_buffer),
    .time_bcd   (current_time)
  );
endmodule

// File: tb/tb_alarm_time_source.sv
// Directed + randomized bench; reference model keeps time as minutes-of-day
// and the key buffer as a digit array.
module tb_alarm_time_source;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        one_minute, key_valid, load_alarm, load_new_time;
  logic [3:0]  key;
  logic [15:0] key_buffer, alarm_time, current_time;
  logic        load_error;

  int vecs = 0;
  int errs = 0;

  int m_kb[4];          // [0]=H tens ... [3]=M units
  int m_alarm_min;
  int m_time_min;
  logic m_err;

  alarm_time_source dut (
    .clk(clk), .rst_n(rst_n), .one_minute(one_minute), .key(key),
    .key_valid(key_valid), .load_alarm(load_alarm), .load_new_time(load_new_time),
    .key_buffer(key_buffer), .alarm_time(alarm_time), .current_time(current_time),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] min_to_bcd(input int m);
    int hh, mm;
    hh = m / 60;
    mm = m % 60;
    return 16'((hh / 10) << 12 | (hh % 10) << 8 | (mm / 10) << 4 | (mm % 10));
  endfunction

  function automatic logic [15:0] kb_bcd();
    return 16'(m_kb[0] << 12 | m_kb[1] << 8 | m_kb[2] << 4 | m_kb[3]);
  endfunction

  function automatic bit kb_legal();
    foreach (m_kb[i]) if (m_kb[i] > 9) return 0;
    return (m_kb[0] * 10 + m_kb[1] < 24) && (m_kb[2] * 10 + m_kb[3] < 60);
  endfunction

  function automatic int kb_minutes();
    return (m_kb[0] * 10 + m_kb[1]) * 60 + m_kb[2] * 10 + m_kb[3];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".key_buffer"},   key_buffer,   kb_bcd());
    chk({tag, ".alarm_time"},   alarm_time,   min_to_bcd(m_alarm_min));
    chk({tag, ".current_time"}, current_time, min_to_bcd(m_time_min));
    chk({tag, ".load_error"},   {15'd0, load_error}, {15'd0, m_err});
  endtask

  task automatic model_reset();
    foreach (m_kb[i]) m_kb[i] = 0;
    m_alarm_min = 6 * 60;
    m_time_min  = 0;
    m_err       = 1'b0;
  endtask

  task automatic step(input string tag, input logic kv, input logic [3:0] k,
                      input logic la, input logic ln, input logic om);
    bit legal;
    @(negedge clk);
    key_valid = kv; key = k; load_alarm = la; load_new_time = ln; one_minute = om;
    @(posedge clk);
    legal = kb_legal();
    if (om && !(ln && legal)) m_time_min = (m_time_min + 1) % 1440;
    if (la || ln) begin
      if (legal && la) m_alarm_min = kb_minutes();
      if (legal && ln) m_time_min  = kb_minutes();
      m_err = !legal;
      foreach (m_kb[i]) m_kb[i] = 0;
    end else begin
      m_err = 1'b0;
      if (kv && k <= 9) begin
        m_kb[0] = m_kb[1]; m_kb[1] = m_kb[2]; m_kb[2] = m_kb[3]; m_kb[3] = int'(k);
      end
    end
    #1;
    chk_all(tag);
    key_valid = 0; load_alarm = 0; load_new_time = 0; one_minute = 0;
  endtask

  task automatic keys(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    step(tag, 1, a, 0, 0, 0);
    step(tag, 1, b, 0, 0, 0);
    step(tag, 1, c, 0, 0, 0);
    step(tag, 1, d, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; key = 0; key_valid = 0; load_alarm = 0; load_new_time = 0; one_minute = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk) rst_n = 1;
    step("idle", 0, 0, 0, 0, 0);

    // alarm 07:30, and a fifth key shifting the oldest digit out
    keys("alarm_keys", 0, 7, 3, 0);
    step("load_alarm", 0, 0, 1, 0, 0);
    chk("alarm_0730", alarm_time, 16'h0730);
    keys("shift_keys", 0, 7, 3, 0);
    step("fifth_key", 1, 5, 0, 0, 0);
    chk("buf_7305", key_buffer, 16'h7305);
    step("clear", 0, 0, 1, 0, 0);     // 73:05 illegal -> error, buffer 0

    // 23:59 wrap and 09:59 hour carry
    keys("t2359", 2, 3, 5, 9);
    step("load_2359", 0, 0, 0, 1, 0);
    chk("time_2359", current_time, 16'h2359);
    step("tick_wrap", 0, 0, 0, 0, 1);
    chk("time_0000", current_time, 16'h0000);
    keys("t0959", 0, 9, 5, 9);
    step("load_0959", 0, 0, 0, 1, 0);
    step("tick_0959", 0, 0, 0, 0, 1);
    chk("time_1000", current_time, 16'h1000);
    keys("t1959", 1, 9, 5, 9);
    step("load_1959", 0, 0, 0, 1, 1);
    step("tick_1959", 0, 0, 0, 0, 1);
    chk("time_2000", current_time, 16'h2000);

    // rejected loads
    keys("bad_2400", 2, 4, 0, 0);
    step("rej_2400", 0, 0, 1, 0, 0);
    chk("err_2400", {15'd0, load_error}, 16'd1);
    step("err_drop", 0, 0, 0, 0, 0);
    keys("bad_1260", 1, 2, 6, 0);
    step("rej_1260", 0, 0, 1, 0, 0);
    step("key11", 1, 11, 0, 0, 0);
    step("key11b", 1, 4, 0, 0, 0);
    step("key15", 1, 15, 0, 0, 0);
    step("bad_time_tick", 0, 0, 0, 1, 1);   // buffer 0004 is legal: load wins
    keys("bad_9999", 9, 9, 9, 9);
    step("rej_time_tick", 0, 0, 0, 1, 1);   // illegal: tick applies

    // same-cycle interactions
    keys("t1200", 1, 2, 0, 0);
    step("load_1200_tick", 0, 0, 0, 1, 1);
    chk("time_1200", current_time, 16'h1200);
    keys("kv_la", 0, 6, 4, 5);
    step("kv_with_la", 1, 7, 1, 0, 0);
    chk("alarm_0645", alarm_time, 16'h0645);
    keys("both", 0, 8, 1, 5);
    step("load_both", 0, 0, 1, 1, 0);
    chk("both_alarm", alarm_time, 16'h0815);
    chk("both_time", current_time, 16'h0815);

    // asynchronous reset mid-entry
    step("pre_rst_a", 1, 3, 0, 0, 0);
    step("pre_rst_b", 1, 4, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk) rst_n = 1;

    // randomized traffic, digits biased toward legal times
    for (int n = 0; n < 400; n++) begin
      logic kv, la, ln, om;
      logic [3:0] k;
      int r;
      r  = $urandom_range(0, 99);
      k  = (r < 85) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
      kv = ($urandom_range(0, 99) < 75);
      la = ($urandom_range(0, 99) < 7);
      ln = ($urandom_range(0, 99) < 7);
      om = ($urandom_range(0, 99) < 30);
      step("rand", kv, k, la, ln, om);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alarm_time_source.md
Name: alarm_time_source

Overview:
- Produces the two 4-digit BCD time buses that the alarm comparator/display mux consumes: the running time-of-day and the stored alarm time.
- Keypad digits shift into a 4-digit key buffer.
- A load strobe commits the buffer into the alarm register or the time counter.
- The time counter advances HH:MM on a one-minute enable and wraps 23:59 -> 00:00.

Parameters:
- RST_TIME, 16'h0000, reset value of current_time (BCD HHMM).
- RST_ALARM, 16'h0600, reset value of alarm_time (BCD HHMM). Must differ from RST_TIME so the alarm does not sound out of reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- one_minute  input  1  single-cycle enable, advance time by one minute.
- key  input  4  keypad digit, valid 0..9.
- key_valid  input  1  single-cycle strobe qualifying key.
- load_alarm  input  1  commit key buffer to alarm register.
- load_new_time  input  1  commit key buffer to time counter.
- key_buffer  output  16  four BCD digits being entered, [15:12]=H tens ... [3:0]=M units.
- alarm_time  output  16  stored alarm, BCD HHMM.
- current_time  output  16  time of day, BCD HHMM.
- load_error  output  1  one-cycle pulse, load rejected (buffer not a legal time).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - key_buffer=0, alarm_time=RST_ALARM, current_time=RST_TIME, load_error=0.
  - Reset mid-entry or mid-load discards all state.
- All outputs are registered. Effects of an input sampled at edge N are visible after edge N.
- Key entry, key_valid=1 and key<=9, no load that cycle:
  - key_buffer <= {key_buffer[11:0], key}; the oldest digit falls off.
  - key>9 with key_valid: ignored, buffer unchanged.
- Legal-time check on key_buffer:
  - H tens<=2; H units<=9, and <=3 when H tens=2; M tens<=5; M units<=9.
- load_alarm=1:
  - If legal, alarm_time <= key_buffer.
  - Either way, key_buffer <= 0.
- load_new_time=1:
  - If legal, current_time <= key_buffer.
  - Either way, key_buffer <= 0.
- load_alarm and load_new_time together: both registers load from the same buffer value (if legal); single buffer clear.
- Illegal buffer on any load: target register(s) unchanged, load_error=1 for exactly one cycle.
- key_valid in the same cycle as a load: the load uses the pre-shift buffer; the key is dropped; the buffer ends at 0.
- Time counter, one_minute=1:
  - M units 9->0 with carry; M tens 5->0 with carry.
  - Hours BCD increment; 23:59 -> 00:00; 09:59 -> 10:00; 19:59 -> 20:00.
- one_minute together with a legal load_new_time: the load wins and the tick is dropped (no +1 applied to the loaded value).
- one_minute together with an illegal load_new_time: the tick applies normally, and load_error pulses.
- Counter states outside legal BCD are unreachable. The counter need not self-correct them.

Decomposition:
- Shared package/include holds:
  - BCD digit width (4), time bus width (16).
  - Digit-position constants (HT, HU, MT, MU slices).
  - Limits: MAX_HT=2, MAX_HU_AT_HT2=3, MAX_MT=5, MAX_DIGIT=9.
  - The legal-time check as a function.
- One sub-module is natural: bcd_time_counter. It holds current_time with ports clk, rst_n, tick, load, load_value, time, and owns the wrap/carry logic.
- Key buffer, alarm register and load arbitration stay in the top.

Test Plan:
- Reset: hold rst_n=0, release -> current_time=16'h0000, alarm_time=16'h0600, key_buffer=0, load_error=0.
- Keys 0,7,3,0 then load_alarm -> alarm_time=16'h0730 next cycle, key_buffer=0. Fifth key 5 before load -> buffer 16'h7305.
- Keys 2,3,5,9, load_new_time, then one_minute -> current_time 16'h2359 then 16'h0000. Also 16'h0959 + tick -> 16'h1000.
- Keys 2,4,0,0 then load_alarm -> load_error high one cycle, alarm_time unchanged, buffer 0. Repeat with 1,2,6,0 -> same rejection. Key 11 with key_valid -> buffer unchanged.
- Same-cycle events:
  - Legal load_new_time 12:00 + one_minute -> current_time=16'h1200, not 12:01.
  - key_valid with load_alarm -> key dropped.
  - load_alarm + load_new_time with buffer 0815 -> both registers =16'h0815.
- Assert rst_n after two digits have been entered -> buffer 0, and times return to RST_TIME/RST_ALARM immediately (asynchronously).
